// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the vote tally block: FSM state encoding, default
// sizing and a helper that classifies a strobe vector as zero / one-hot /
// multiple bits set.
// ---------------------------------------------------------------------------
package vote_pkg;

  localparam int DEF_NUM_CAND = 4;
  localparam int DEF_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_LOCK   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OH_ZERO  = 2'd0,
    OH_ONE   = 2'd1,
    OH_MULTI = 2'd2
  } oh_t;

  // Strobe vectors are at most 8 bits wide; narrower vectors are
  // zero-extended by the caller.
  function automatic oh_t onehot_check(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n = n + int'(v[i]);
    end
    if (n == 0) begin
      return OH_ZERO;
    end else if (n == 1) begin
      return OH_ONE;
    end
    return OH_MULTI;
  endfunction

endpackage

// File: rtl/vote_sat_counter.sv
// ---------------------------------------------------------------------------
// vote_sat_counter
// CNT_W-bit up counter that holds at its maximum value instead of wrapping.
// Ports:
//   clk_i    system clock
//   clr_n_i  synchronous active-low clear
//   inc_i    increment enable (ignored once saturated)
//   cnt_o    current count
// ---------------------------------------------------------------------------
module vote_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vote_tally.sv
// ---------------------------------------------------------------------------
// vote_tally
// Consumes 1-cycle per-candidate vote strobes from the button controllers,
// keeps one saturating tally per candidate, enforces a lockout window after
// each accepted vote, rejects simultaneous strobes and serves the tallies
// to the display path in result mode.
//
// Optional feature (macro VOTE_TOTAL_EN): adds output total_votes, a count
// of all accepted votes that saturates only at its own maximum.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-low reset
//   valid_vote   NUM_CAND vote strobes, one bit per candidate
//   mode         0 = voting, 1 = result readout
//   sel          candidate index for readout (>= NUM_CAND reads as 0)
//   vote_ack     1-cycle pulse: vote accepted
//   vote_rej     1-cycle pulse: more than one strobe bit while idle
//   vote_led     one-hot of last accepted candidate, held during lockout
//   busy         high while accepting or locked out
//   count_out    registered tally of candidate sel in result mode, else 0
//   total_votes  (VOTE_TOTAL_EN only) total accepted votes
// ---------------------------------------------------------------------------
module vote_tally
  import vote_pkg::*;
#(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCKOUT  = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CAND-1:0] valid_vote,
  input  logic                mode,
  input  logic [2:0]          sel,
`ifdef VOTE_TOTAL_EN
  output logic [CNT_W+3:0]    total_votes,
`endif
  output logic                vote_ack,
  output logic                vote_rej,
  output logic [NUM_CAND-1:0] vote_led,
  output logic                busy,
  output logic [CNT_W-1:0]    count_out
);

  localparam int SEL_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int LCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  state_t              state_q, state_d;
  logic [NUM_CAND-1:0] cand_q, cand_d;
  logic [NUM_CAND-1:0] led_q, led_d;
  logic                rej_q, rej_d;
  logic [LCK_W-1:0]    lock_q, lock_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  oh_t                 oh;

  assign oh = onehot_check(8'(valid_vote));

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    led_d   = led_q;
    rej_d   = 1'b0;
    lock_d  = lock_q;
    case (state_q)
      ST_IDLE: begin
        // mode wins over strobes arriving in the same cycle
        if (mode) begin
          state_d = ST_RESULT;
        end else begin
          case (oh)
            OH_ONE: begin
              cand_d  = valid_vote;
              state_d = ST_ACCEPT;
            end
            OH_MULTI: rej_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_ACCEPT: begin
        lock_d  = LCK_W'(LOCKOUT - 1);
        led_d   = cand_q;
        state_d = ST_LOCK;
      end
      ST_LOCK: begin
        // the cycle that reads 0 is the last LOCK cycle, giving LOCKOUT cycles
        if (lock_q == '0) begin
          led_d   = '0;
          state_d = ST_IDLE;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      ST_RESULT: begin
        if (!mode) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Keyed off the next state so the readout tracks sel/mode with one cycle
  // of latency and drops to 0 in the cycle after leaving result mode.
  always_comb begin
    count_d = '0;
    if ((state_d == ST_RESULT) && (int'(sel) < NUM_CAND)) begin
      count_d = tally[sel[SEL_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      led_q   <= '0;
      rej_q   <= 1'b0;
      lock_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      led_q   <= led_d;
      rej_q   <= rej_d;
      lock_q  <= lock_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    vote_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (clk),
      .clr_n_i (rst),
      .inc_i   ((state_q == ST_ACCEPT) && cand_q[g]),
      .cnt_o   (tally[g])
    );
  end

`ifdef VOTE_TOTAL_EN
  logic [CNT_W+3:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if ((state_q == ST_ACCEPT) && (total_q != {(CNT_W+4){1'b1}})) begin
      total_d = total_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_votes = total_q;
`endif

  assign vote_ack  = (state_q == ST_ACCEPT);
  assign vote_rej  = rej_q;
  assign vote_led  = led_q;
  assign busy      = (state_q == ST_ACCEPT) || (state_q == ST_LOCK);
  assign count_out = count_q;

endmodule

// File: tb/tb_vote_tally.sv
module tb_vote_tally;

  localparam int NC = 4;

  logic          clk;
  logic          rst;
  logic          mode;
  logic [2:0]    sel;
  logic [NC-1:0] vv_a, vv_b;

  logic          ack_a, rej_a, busy_a;
  logic [NC-1:0] led_a;
  logic [7:0]    cnt_a;
  logic          ack_b, rej_b, busy_b;
  logic [NC-1:0] led_b;
  logic [1:0]    cnt_b;
`ifdef VOTE_TOTAL_EN
  logic [11:0]   tot_a;
  logic [5:0]    tot_b;
`endif

  int checks = 0;
  int errors = 0;

  vote_tally #(.NUM_CAND(NC), .CNT_W(8), .LOCKOUT(100)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .valid_vote (vv_a),
    .mode       (mode),
    .sel        (sel),
`ifdef VOTE_TOTAL_EN
    .total_votes(tot_a),
`endif
    .vote_ack   (ack_a),
    .vote_rej   (rej_a),
    .vote_led   (led_a),
    .busy       (busy_a),
    .count_out  (cnt_a)
  );

  vote_tally #(.NUM_CAND(NC), .CNT_W(2), .LOCKOUT(4)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .valid_vote (vv_b),
    .mode       (mode),
    .sel        (sel),
`ifdef VOTE_TOTAL_EN
    .total_votes(tot_b),
`endif
    .vote_ack   (ack_b),
    .vote_rej   (rej_b),
    .vote_led   (led_b),
    .busy       (busy_b),
    .count_out  (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_a(input logic [2:0] s, input logic [7:0] exp, input string tag);
    mode = 1'b1;
    sel  = s;
    tick();
    check(tag, 32'(cnt_a), 32'(exp));
  endtask

  int led_cnt, busy_cnt;

  initial begin
    rst = 1'b0; mode = 1'b0; sel = 3'd0; vv_a = '0; vv_b = '0;
    tick(2);
    check("rst_ack",  32'(ack_a),  0);
    check("rst_rej",  32'(rej_a),  0);
    check("rst_led",  32'(led_a),  0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_cnt",  32'(cnt_a),  0);
    rst = 1'b1;
    tick();

    // single vote for candidate 1
    vv_a = 4'b0010;
    tick();
    vv_a = '0;
    check("sv_ack",  32'(ack_a),  1);
    check("sv_busy", 32'(busy_a), 1);
    led_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (led_a == 4'b0010) led_cnt++;
      if (busy_a) busy_cnt++;
    end
    check("sv_led_cycles",  32'(led_cnt),  100);
    check("sv_lock_cycles", 32'(busy_cnt), 100);
    check("sv_idle_led",    32'(led_a),    0);
    read_a(3'd1, 8'd1, "sv_tally1");
    read_a(3'd0, 8'd0, "sv_tally0");
    mode = 1'b0;
    tick();
    check("sv_exit_cnt", 32'(cnt_a), 0);

    // simultaneous strobes
    vv_a = 4'b0101;
    tick();
    vv_a = '0;
    check("sim_rej", 32'(rej_a), 1);
    check("sim_ack", 32'(ack_a), 0);
    tick();
    check("sim_rej_pulse", 32'(rej_a),  0);
    check("sim_busy",      32'(busy_a), 0);
    read_a(3'd0, 8'd0, "sim_tally0");
    read_a(3'd2, 8'd0, "sim_tally2");
    read_a(3'd1, 8'd1, "sim_tally1");
    mode = 1'b0;
    tick();

    // lockout: strobe at +5 ignored, strobe at +LOCKOUT+2 accepted
    vv_a = 4'b0001;
    tick();
    vv_a = '0;
    check("lo_ack0", 32'(ack_a), 1);
    tick(4);
    vv_a = 4'b1000;
    tick();
    vv_a = '0;
    check("lo_ign_ack",  32'(ack_a),  0);
    check("lo_ign_rej",  32'(rej_a),  0);
    check("lo_ign_busy", 32'(busy_a), 1);
    tick(96);
    check("lo_idle", 32'(busy_a), 0);
    vv_a = 4'b1000;
    tick();
    vv_a = '0;
    check("lo_acc_ack", 32'(ack_a), 1);
    tick(105);
    read_a(3'd0, 8'd1, "lo_tally0");
    read_a(3'd3, 8'd1, "lo_tally3");
`ifdef VOTE_TOTAL_EN
    check("lo_total", 32'(tot_a), 3);
`endif
    mode = 1'b0;
    tick();

    // mode priority over a strobe in the same idle cycle
    mode = 1'b1; sel = 3'd0; vv_a = 4'b0001;
    tick();
    vv_a = '0;
    check("mp_ack",  32'(ack_a),  0);
    check("mp_rej",  32'(rej_a),  0);
    check("mp_busy", 32'(busy_a), 0);
    check("mp_cnt",  32'(cnt_a),  1);
    tick();
    check("mp_cnt_hold", 32'(cnt_a), 1);
    read_a(3'd7, 8'd0, "mp_sel7");
    read_a(3'd3, 8'd1, "mp_sel3");
    mode = 1'b0;
    tick();

    // reset during lockout
    vv_a = 4'b0100;
    tick();
    vv_a = '0;
    tick(10);
    check("rl_busy", 32'(busy_a), 1);
    check("rl_led",  32'(led_a),  4'b0100);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rl_ack",  32'(ack_a),  0);
    check("rl_rej",  32'(rej_a),  0);
    check("rl_led0", 32'(led_a),  0);
    check("rl_busy0",32'(busy_a), 0);
    check("rl_cnt",  32'(cnt_a),  0);
    vv_a = 4'b0010;
    tick();
    vv_a = '0;
    check("rl_new_ack", 32'(ack_a), 1);
    tick(105);
    read_a(3'd1, 8'd1, "rl_tally1");
    read_a(3'd2, 8'd0, "rl_tally2");
    read_a(3'd0, 8'd0, "rl_tally0");
`ifdef VOTE_TOTAL_EN
    check("rl_total", 32'(tot_a), 1);
`endif
    mode = 1'b0;
    tick();

    // saturation on the 2-bit instance
    for (int v = 0; v < 5; v++) begin
      vv_b = 4'b0100;
      tick();
      vv_b = '0;
      check("sat_ack", 32'(ack_b), 1);
      tick(8);
    end
    mode = 1'b1; sel = 3'd2;
    tick();
    check("sat_cnt2", 32'(cnt_b), 3);
    sel = 3'd1;
    tick();
    check("sat_cnt1", 32'(cnt_b), 0);
`ifdef VOTE_TOTAL_EN
    check("sat_total", 32'(tot_b), 5);
`endif
    mode = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
